// File: rtl/ftdi_rx_reader_if.sv
// FT600 read-side bus bundle: FTDI pins, FWFT stream and status.
// master = ftdi_rx_reader, slave = the consumer/host model that drives the inputs.
interface ftdi_rx_reader_if #(
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              rxf_n_in;
  logic [DATA_W-1:0] data_in;
  logic [BE_W-1:0]   be_in;
  logic              rd_n_out;
  logic              oe_n_out;
  logic [DATA_W-1:0] m_data_out;
  logic [BE_W-1:0]   m_be_out;
  logic              m_valid_out;
  logic              m_ready_in;
  logic              busy_out;
  logic              overflow_out;
  logic [31:0]       rx_words_out;

  modport master (
    input  rxf_n_in, data_in, be_in, m_ready_in,
    output rd_n_out, oe_n_out, m_data_out, m_be_out, m_valid_out,
           busy_out, overflow_out, rx_words_out
  );

  modport slave (
    output rxf_n_in, data_in, be_in, m_ready_in,
    input  rd_n_out, oe_n_out, m_data_out, m_be_out, m_valid_out,
           busy_out, overflow_out, rx_words_out
  );
endinterface

// File: rtl/ftdi_rx_reader.sv
// FT600 245-sync read engine: OE_N/RD_N sequencing, capture FIFO, FWFT stream out.
// Optional FTDI_RX_BE_MASK_EN: zero disabled bytes on push and store BE; otherwise BE reads as all-ones.
module ftdi_rx_reader #(
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_SLACK = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  ftdi_rx_reader_if.master bus
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] SLACK_C = (AW+1)'(STOP_SLACK);

  typedef enum logic [1:0] {IDLE, OE, READ, STOP} state_t;

  state_t            state;
  logic              rd_n;
  logic              oe_n;
  logic              busy;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic [AW:0]       free_now;
  logic [AW:0]       free_nxt;
  logic              valid;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              overflow;
  logic [31:0]       rx_words;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

`ifdef FTDI_RX_BE_MASK_EN
  logic [BE_W-1:0] be_mem [FIFO_DEPTH];

  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < BE_W; i++) begin
      if (!be[i]) r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction
`else
  logic unused_be;
  assign unused_be = ^bus.be_in;
`endif

  // READ captures while RD_N is low; STOP takes the one trailing word.
  assign push_req = ((state == READ) || (state == STOP)) && !bus.rxf_n_in;
  assign valid    = (count != '0);
  assign pop      = valid && bus.m_ready_in;
  assign full     = (count == DEPTH_C);
  assign push_ok  = push_req && (!full || pop);
  assign free_now = DEPTH_C - count;
  assign free_nxt = DEPTH_C - count_nxt;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + 1'b1;
    else if (!push_ok && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
`ifdef FTDI_RX_BE_MASK_EN
      data_mem[wr_ptr] <= mask_bytes(bus.data_in, bus.be_in);
      be_mem[wr_ptr]   <= bus.be_in;
`else
      data_mem[wr_ptr] <= bus.data_in;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rx_words <= '0;
    end else begin
      count <= count_nxt;
      if (push_ok) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_words <= rx_words + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Pin outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      rd_n  <= 1'b1;
      oe_n  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.rxf_n_in && (free_now > SLACK_C)) begin
            state <= OE;
            oe_n  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        OE: begin
          state <= READ;
          rd_n  <= 1'b0;
        end
        READ: begin
          if (bus.rxf_n_in || (free_nxt <= SLACK_C)) begin
            state <= STOP;
            rd_n  <= 1'b1;
          end
        end
        STOP: begin
          state <= IDLE;
          oe_n  <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rd_n  <= 1'b1;
          oe_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_n_out     = rd_n;
  assign bus.oe_n_out     = oe_n;
  assign bus.busy_out     = busy;
  assign bus.overflow_out = overflow;
  assign bus.rx_words_out = rx_words;
  assign bus.m_valid_out  = valid;
  // Stream outputs read zero while empty so reset leaves them at zero.
  assign bus.m_data_out   = valid ? data_mem[rd_ptr] : '0;
`ifdef FTDI_RX_BE_MASK_EN
  assign bus.m_be_out     = valid ? be_mem[rd_ptr] : '0;
`else
  assign bus.m_be_out     = valid ? '1 : '0;
`endif
endmodule

// File: tb/tb_ftdi_rx_reader.sv
// Self-checking bench for ftdi_rx_reader: FT600 host emulation, queue scoreboard, two DUT configurations.
module tb_ftdi_rx_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ftdi_rx_reader_if #(.DATA_W(32), .BE_W(4)) bus ();
  ftdi_rx_reader_if #(.DATA_W(32), .BE_W(4)) bus_o ();

  ftdi_rx_reader #(.DATA_W(32), .BE_W(4), .FIFO_DEPTH(16), .STOP_SLACK(3))
    u_dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  // Zero slack lets the FIFO fill so a trailing word meets a full FIFO.
  ftdi_rx_reader #(.DATA_W(32), .BE_W(4), .FIFO_DEPTH(8), .STOP_SLACK(0))
    u_ovf (.clk_in(clk), .rst_in(rst), .bus(bus_o));

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          sel     = 1'b0;
  logic [35:0] host_q[$];
  logic [35:0] fifo_m[$];
  logic [35:0] sent_q[$];
  logic [35:0] obs_q[$];
  int          cap_cyc[$];
  int          m_rx;
  bit          m_ovf;
  int          cap_cnt;
  int          stop_after;
  bit          ovr_en;
  logic        ovr_val;
  int          rdy_mode;
  logic        prev_rd;
  int          cyc = 0;
  logic        drv_rx;
  logic        drv_rdy;
  logic [31:0] drv_d;
  logic [3:0]  drv_b;

  function automatic logic [35:0] exp_word(input logic [35:0] w);
    logic [31:0] d;
    d = w[31:0];
`ifdef FTDI_RX_BE_MASK_EN
    for (int i = 0; i < 4; i++) if (!w[32+i]) d[8*i +: 8] = 8'h00;
    return {w[35:32], d};
`else
    return {4'hF, d};
`endif
  endfunction

  function automatic logic cur_rd();     return sel ? bus_o.rd_n_out     : bus.rd_n_out;     endfunction
  function automatic logic cur_oe();     return sel ? bus_o.oe_n_out     : bus.oe_n_out;     endfunction
  function automatic logic cur_valid();  return sel ? bus_o.m_valid_out  : bus.m_valid_out;  endfunction
  function automatic logic cur_busy();   return sel ? bus_o.busy_out     : bus.busy_out;     endfunction
  function automatic logic cur_ovf();    return sel ? bus_o.overflow_out : bus.overflow_out; endfunction
  function automatic logic [31:0] cur_rx(); return sel ? bus_o.rx_words_out : bus.rx_words_out; endfunction
  function automatic logic [35:0] cur_word();
    return sel ? {bus_o.m_be_out, bus_o.m_data_out} : {bus.m_be_out, bus.m_data_out};
  endfunction

  function automatic int first_diff();
    if (obs_q.size() != sent_q.size()) return -2;
    foreach (obs_q[i]) if (obs_q[i] !== sent_q[i]) return i;
    return -1;
  endfunction

  task automatic drive_inputs();
    drv_rx = ovr_en ? ovr_val : !(host_q.size() > 0 && cap_cnt < stop_after);
    if (host_q.size() > 0) begin
      drv_d = host_q[0][31:0];
      drv_b = host_q[0][35:32];
    end else begin
      drv_d = $urandom;
      drv_b = 4'($urandom);
    end
    case (rdy_mode)
      0:       drv_rdy = 1'b0;
      1:       drv_rdy = 1'b1;
      default: drv_rdy = 1'($urandom_range(0, 1));
    endcase
    bus.rxf_n_in     = sel ? 1'b1 : drv_rx;
    bus.data_in      = drv_d;
    bus.be_in        = drv_b;
    bus.m_ready_in   = sel ? 1'b0 : drv_rdy;
    bus_o.rxf_n_in   = sel ? drv_rx : 1'b1;
    bus_o.data_in    = drv_d;
    bus_o.be_in      = drv_b;
    bus_o.m_ready_in = sel ? drv_rdy : 1'b0;
  endtask

  // Host side of the FT600: a word leaves the host when it is read with RD_N low,
  // or as the trailing word in the cycle right after RD_N rises while OE_N stays low.
  task automatic tick();
    logic cap, pop, full;
    int   depth;
    depth = sel ? 8 : 16;
    cap   = !drv_rx && (!cur_rd() || (!cur_oe() && !prev_rd));
    pop   = cur_valid() && drv_rdy;
    full  = (fifo_m.size() == depth);
    if (pop) begin
      obs_q.push_back(cur_word());
      if (fifo_m.size() > 0) void'(fifo_m.pop_front());
    end
    if (cap) begin
      cap_cnt++;
      cap_cyc.push_back(cyc);
      if (host_q.size() > 0) void'(host_q.pop_front());
      if (full && !pop) m_ovf = 1'b1;
      else begin
        fifo_m.push_back(exp_word({drv_b, drv_d}));
        sent_q.push_back(exp_word({drv_b, drv_d}));
        m_rx++;
      end
    end
    prev_rd = cur_rd();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_inputs();
  endtask

  task automatic clear_model();
    host_q.delete(); fifo_m.delete(); sent_q.delete(); obs_q.delete(); cap_cyc.delete();
    m_rx = 0; m_ovf = 1'b0; cap_cnt = 0; stop_after = 32'h7fff_ffff;
    ovr_en = 1'b0; ovr_val = 1'b1; rdy_mode = 0; prev_rd = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int limit, output bit ok);
    int n;
    n = 0;
    while ((host_q.size() > 0 || fifo_m.size() > 0) && n < limit) begin
      tick();
      n++;
    end
    ok = (n < limit);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    drive_inputs();
    repeat (2) @(negedge clk);
    n_tests++; if (bus.rd_n_out !== 1'b1 || bus.oe_n_out !== 1'b1) begin n_fail++;
      $display("FAIL reset_pins: rd_n=%b oe_n=%b, want 1 1", bus.rd_n_out, bus.oe_n_out); end
    n_tests++; if (bus.m_valid_out !== 1'b0 || bus.m_data_out !== 32'h0 || bus.m_be_out !== 4'h0) begin n_fail++;
      $display("FAIL reset_stream: valid=%b data=%h be=%h, want 0 0 0", bus.m_valid_out, bus.m_data_out, bus.m_be_out); end
    n_tests++; if (bus.busy_out !== 1'b0 || bus.overflow_out !== 1'b0 || bus.rx_words_out !== 32'd0) begin n_fail++;
      $display("FAIL reset_status: busy=%b ovf=%b rx=%0d, want 0 0 0", bus.busy_out, bus.overflow_out, bus.rx_words_out); end
    n_tests++; if (bus_o.rd_n_out !== 1'b1 || bus_o.oe_n_out !== 1'b1 || bus_o.m_valid_out !== 1'b0) begin n_fail++;
      $display("FAIL reset_ovf_dut: rd_n=%b oe_n=%b valid=%b, want 1 1 0", bus_o.rd_n_out, bus_o.oe_n_out, bus_o.m_valid_out); end
    rst = 1'b0;
    repeat (3) tick();
    n_tests++; if (cur_busy() !== 1'b0 || cur_oe() !== 1'b1) begin n_fail++;
      $display("FAIL idle_no_rxf: busy=%b oe_n=%b, want 0 1", cur_busy(), cur_oe()); end
  endtask

  task automatic test_basic();
    int t_oe, t_rd, d;
    bit good;
    t_oe = -1; t_rd = -1; good = 1'b1;
    do_reset();
    rdy_mode = 1;
    for (int i = 1; i <= 8; i++) host_q.push_back({4'hF, 32'(i)});
    drive_inputs();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cur_oe() === 1'b0 && t_oe < 0) t_oe = i;
      if (cur_rd() === 1'b0 && t_rd < 0) t_rd = i;
    end
    n_tests++; if (t_oe < 0 || t_rd - t_oe != 1) begin n_fail++;
      $display("FAIL basic_oe_before_rd: oe at %0d rd at %0d, want rd one cycle after oe", t_oe, t_rd); end
    if (obs_q.size() != 8) good = 1'b0;
    else for (int i = 0; i < 8; i++) if (obs_q[i] !== {4'hF, 32'(i+1)}) good = 1'b0;
    n_tests++; if (!good) begin n_fail++;
      $display("FAIL basic_stream: got %0d words (first %h), want 0x1..0x8", obs_q.size(), obs_q.size() ? obs_q[0] : 36'h0); end
    d = first_diff();
    n_tests++; if (d != -1) begin n_fail++;
      $display("FAIL basic_model: first difference %0d, got %0d words want %0d", d, obs_q.size(), sent_q.size()); end
    n_tests++; if (cur_rx() !== 32'd8) begin n_fail++;
      $display("FAIL basic_rx_words: got %0d, want 8", cur_rx()); end
    n_tests++; if (cap_cyc.size() != 8 || cap_cyc[cap_cyc.size()-1] - cap_cyc[0] != 7) begin n_fail++;
      $display("FAIL basic_throughput: %0d captures, want 8 on consecutive edges", cap_cyc.size()); end
    n_tests++; if (cur_busy() !== 1'b0 || cur_rd() !== 1'b1 || cur_oe() !== 1'b1) begin n_fail++;
      $display("FAIL basic_idle_after: busy=%b rd_n=%b oe_n=%b, want 0 1 1", cur_busy(), cur_rd(), cur_oe()); end
  endtask

  task automatic test_backpressure();
    bit stable, ok;
    int d;
    stable = 1'b1;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) host_q.push_back({4'hF, $urandom});
    drive_inputs();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cur_valid() === 1'b1 && sent_q.size() > 0 && cur_word() !== sent_q[0]) stable = 1'b0;
    end
    // 13 words leave free=3, then one trailing word in STOP.
    n_tests++; if (cur_rx() !== 32'd14) begin n_fail++;
      $display("FAIL bp_stop_point: rx_words=%0d, want 14", cur_rx()); end
    n_tests++; if (cur_ovf() !== 1'b0) begin n_fail++;
      $display("FAIL bp_no_overflow: overflow=%b, want 0", cur_ovf()); end
    n_tests++; if (cur_rd() !== 1'b1 || cur_oe() !== 1'b1 || cur_busy() !== 1'b0) begin n_fail++;
      $display("FAIL bp_parked: rd_n=%b oe_n=%b busy=%b, want 1 1 0", cur_rd(), cur_oe(), cur_busy()); end
    n_tests++; if (cur_valid() !== 1'b1 || !stable) begin n_fail++;
      $display("FAIL bp_stall_stable: valid=%b stable=%b, want 1 1", cur_valid(), stable); end
    rdy_mode = 2;
    drain(2000, ok);
    n_tests++; if (!ok) begin n_fail++;
      $display("FAIL bp_drain_timeout: host left %0d fifo left %0d, want 0 0", host_q.size(), fifo_m.size()); end
    d = first_diff();
    n_tests++; if (d != -1) begin n_fail++;
      $display("FAIL bp_order: first difference %0d, got %0d words want %0d", d, obs_q.size(), sent_q.size()); end
    n_tests++; if (cur_rx() !== 32'd40 || cur_ovf() !== 1'b0) begin n_fail++;
      $display("FAIL bp_totals: rx_words=%0d ovf=%b, want 40 0", cur_rx(), cur_ovf()); end
  endtask

  task automatic test_early_stop();
    logic [35:0] orig[$];
    int  n;
    bit  good;
    good = 1'b1;
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      host_q.push_back({4'($urandom), $urandom});
      orig.push_back(host_q[i]);
    end
    stop_after = 5;
    drive_inputs();
    n = 0;
    while (cap_cnt < 5 && n < 50) begin tick(); n++; end
    n_tests++; if (n >= 50) begin n_fail++;
      $display("FAIL early_capture_timeout: captured %0d, want 5", cap_cnt); end
    tick();
    tick();
    n_tests++; if (cur_rd() !== 1'b1 || cur_oe() !== 1'b1 || cur_busy() !== 1'b0) begin n_fail++;
      $display("FAIL early_release: rd_n=%b oe_n=%b busy=%b two cycles after rxf high, want 1 1 0", cur_rd(), cur_oe(), cur_busy()); end
    repeat (6) tick();
    if (obs_q.size() != 5) good = 1'b0;
    else for (int i = 0; i < 5; i++) if (obs_q[i] !== exp_word(orig[i])) good = 1'b0;
    n_tests++; if (!good) begin n_fail++;
      $display("FAIL early_words: got %0d words, want first 5 host words", obs_q.size()); end
    n_tests++; if (cur_rx() !== 32'd5) begin n_fail++;
      $display("FAIL early_rx_words: got %0d, want 5", cur_rx()); end
  endtask

  task automatic test_empty_read();
    do_reset();
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    drive_inputs();
    ovr_val = 1'b1;
    tick();
    tick();
    n_tests++; if (cur_rd() !== 1'b0 || cur_oe() !== 1'b0) begin n_fail++;
      $display("FAIL empty_in_read: rd_n=%b oe_n=%b, want 0 0", cur_rd(), cur_oe()); end
    tick();
    n_tests++; if (cur_rd() !== 1'b1 || cur_oe() !== 1'b0 || cur_busy() !== 1'b1) begin n_fail++;
      $display("FAIL empty_stop: rd_n=%b oe_n=%b busy=%b, want 1 0 1", cur_rd(), cur_oe(), cur_busy()); end
    tick();
    n_tests++; if (cur_oe() !== 1'b1 || cur_busy() !== 1'b0 || cur_rx() !== 32'd0 || cur_valid() !== 1'b0) begin n_fail++;
      $display("FAIL empty_idle: oe_n=%b busy=%b rx=%0d valid=%b, want 1 0 0 0", cur_oe(), cur_busy(), cur_rx(), cur_valid()); end
  endtask

  task automatic test_overflow();
    logic [35:0] orig[$];
    bit ok, good;
    good = 1'b1;
    sel = 1'b1;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) begin
      host_q.push_back({4'($urandom), $urandom});
      orig.push_back(host_q[i]);
    end
    drive_inputs();
    repeat (30) tick();
    n_tests++; if (cur_ovf() !== 1'b1 || m_ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_set: overflow=%b, want 1", cur_ovf()); end
    n_tests++; if (cur_rx() !== 32'd8) begin n_fail++;
      $display("FAIL ovf_rx_words: got %0d, want 8 (dropped word not counted)", cur_rx()); end
    repeat (10) tick();
    n_tests++; if (cur_ovf() !== 1'b1 || cur_rx() !== 32'd8 || cur_busy() !== 1'b0) begin n_fail++;
      $display("FAIL ovf_sticky: overflow=%b rx=%0d busy=%b, want 1 8 0", cur_ovf(), cur_rx(), cur_busy()); end
    rdy_mode = 1;
    drain(500, ok);
    n_tests++; if (!ok) begin n_fail++;
      $display("FAIL ovf_drain_timeout: host left %0d fifo left %0d, want 0 0", host_q.size(), fifo_m.size()); end
    if (obs_q.size() != 11) good = 1'b0;
    else begin
      for (int i = 0; i < 8; i++)  if (obs_q[i] !== exp_word(orig[i])) good = 1'b0;
      for (int i = 8; i < 11; i++) if (obs_q[i] !== exp_word(orig[i+1])) good = 1'b0;
    end
    n_tests++; if (!good) begin n_fail++;
      $display("FAIL ovf_contents: got %0d words, want 11 with host word 8 dropped", obs_q.size()); end
    n_tests++; if (cur_rx() !== 32'd11 || cur_ovf() !== 1'b1) begin n_fail++;
      $display("FAIL ovf_final: rx=%0d overflow=%b, want 11 1", cur_rx(), cur_ovf()); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n, d;
    bit ok;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 30; i++) host_q.push_back({4'hF, $urandom});
    drive_inputs();
    n = 0;
    while (cur_rd() !== 1'b0 && n < 20) begin tick(); n++; end
    n_tests++; if (n >= 20) begin n_fail++;
      $display("FAIL midrst_no_read: rd_n=%b, want 0 before reset", cur_rd()); end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_tests++; if (cur_rd() !== 1'b1 || cur_oe() !== 1'b1 || cur_valid() !== 1'b0) begin n_fail++;
      $display("FAIL midrst_async: rd_n=%b oe_n=%b valid=%b, want 1 1 0", cur_rd(), cur_oe(), cur_valid()); end
    n_tests++; if (cur_busy() !== 1'b0 || cur_rx() !== 32'd0 || bus.m_data_out !== 32'h0) begin n_fail++;
      $display("FAIL midrst_status: busy=%b rx=%0d data=%h, want 0 0 0", cur_busy(), cur_rx(), bus.m_data_out); end
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) host_q.push_back({4'hF, $urandom});
    drive_inputs();
    drain(500, ok);
    d = first_diff();
    n_tests++; if (!ok || d != -1 || cur_rx() !== 32'd6) begin n_fail++;
      $display("FAIL midrst_restart: ok=%b diff=%0d rx=%0d, want 1 -1 6", ok, d, cur_rx()); end
  endtask

  task automatic test_be_mask();
    logic [35:0] want;
    int  n, d;
    bit  ok;
`ifdef FTDI_RX_BE_MASK_EN
    want = {4'b0101, 32'h00BB_00DD};
`else
    want = {4'hF, 32'hAABB_CCDD};
`endif
    do_reset();
    rdy_mode = 0;
    host_q.push_back({4'b0101, 32'hAABB_CCDD});
    for (int i = 0; i < 5; i++) host_q.push_back({4'($urandom), $urandom});
    drive_inputs();
    n = 0;
    while (cur_valid() !== 1'b1 && n < 20) begin tick(); n++; end
    n_tests++; if (cur_word() !== want) begin n_fail++;
      $display("FAIL be_mask_word: got be/data %h, want %h", cur_word(), want); end
    rdy_mode = 2;
    drain(500, ok);
    d = first_diff();
    n_tests++; if (!ok || d != -1) begin n_fail++;
      $display("FAIL be_mask_stream: ok=%b first difference %0d, want 1 -1", ok, d); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_stop();
    test_empty_read();
    test_overflow();
    test_reset_mid_burst();
    test_be_mask();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
